// File: rtl/wfg_mem_wb_port.sv
// Wishbone classic slave giving the management SoC read/write access to the two
// pattern SRAM macros through their 1rw port 0, as one contiguous 1024-word window.
module wfg_mem_wb_port #(
    parameter logic [31:0] BASE_ADDR = 32'h3010_0000,
    parameter int          MEM_AW    = 9,
    parameter int          DW        = 32
) (
    input  logic              io_wbs_clk,
    input  logic              io_wbs_rst,
    input  logic              io_wbs_cyc,
    input  logic              io_wbs_stb,
    input  logic              io_wbs_we,
    input  logic [DW/8-1:0]   io_wbs_sel,
    input  logic [31:0]       io_wbs_adr,
    input  logic [DW-1:0]     io_wbs_datwr,
    output logic [DW-1:0]     io_wbs_datrd,
    output logic              io_wbs_ack,
    output logic              csb0_mem0,
    output logic              csb0_mem1,
    output logic              web0,
    output logic [DW/8-1:0]   wmask0,
    output logic [MEM_AW-1:0] addr0,
    output logic [DW-1:0]     din0,
    input  logic [DW-1:0]     dout0_mem0,
    input  logic [DW-1:0]     dout0_mem1
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_e;

    localparam logic [19:0] BASE_PAGE = BASE_ADDR[31:12];

    state_e              state_q;
    logic                msel_q, we_q, abort_q;
    logic                ack_q, csb0_q, csb1_q, web_q;
    logic [DW-1:0]       datrd_q, din_q;
    logic [DW/8-1:0]     wmask_q;
    logic [MEM_AW-1:0]   addr_q;

    logic                req, hit;
    logic [MEM_AW:0]     widx;
    logic                unused_adr_lsb;

    assign req            = io_wbs_cyc & io_wbs_stb;
    assign hit            = req & (io_wbs_adr[31:12] == BASE_PAGE);
    assign widx           = io_wbs_adr[MEM_AW+2:2];
    assign unused_adr_lsb = ^io_wbs_adr[1:0];

    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            state_q <= IDLE;
            msel_q  <= 1'b0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            ack_q   <= 1'b0;
            datrd_q <= '0;
            csb0_q  <= 1'b1;
            csb1_q  <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= 1'b0;
                    abort_q <= 1'b0;
                    if (hit) begin
                        addr_q  <= widx[MEM_AW-1:0];
                        din_q   <= io_wbs_datwr;
                        wmask_q <= io_wbs_we ? io_wbs_sel : '0;
                        web_q   <= ~io_wbs_we;
                        csb0_q  <= widx[MEM_AW];
                        csb1_q  <= ~widx[MEM_AW];
                        msel_q  <= widx[MEM_AW];
                        we_q    <= io_wbs_we;
                        state_q <= ACCESS;
                    end else begin
                        csb0_q <= 1'b1;
                        csb1_q <= 1'b1;
                        web_q  <= 1'b1;
                    end
                end
                ACCESS: begin
                    // SRAM samples at the end of this cycle; release it right after
                    csb0_q  <= 1'b1;
                    csb1_q  <= 1'b1;
                    web_q   <= 1'b1;
                    wmask_q <= '0;
                    if (we_q) begin
                        ack_q   <= req;
                        state_q <= req ? ACK : IDLE;
                    end else begin
                        abort_q <= ~req;
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // an aborted read completes in the SRAM but returns nothing
                    if (req && !abort_q) begin
                        datrd_q <= msel_q ? dout0_mem1 : dout0_mem0;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_wbs_ack   = ack_q;
    assign io_wbs_datrd = datrd_q;
    assign csb0_mem0    = csb0_q;
    assign csb0_mem1    = csb1_q;
    assign web0         = web_q;
    assign wmask0       = wmask_q;
    assign addr0        = addr_q;
    assign din0         = din_q;

endmodule

// File: tb/tb_wfg_mem_wb_port.sv
// Bench for wfg_mem_wb_port: hand vectors, corner sequences and random traffic
// checked against a word-array model of the 1024-word pattern window.
module tb_wfg_mem_wb_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, datwr;
    logic [31:0] datrd;
    logic        ack, csb0_mem0, csb0_mem1, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0, dout0_mem0, dout0_mem1;

    wfg_mem_wb_port dut (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_cyc(cyc), .io_wbs_stb(stb),
        .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
        .io_wbs_datrd(datrd), .io_wbs_ack(ack), .csb0_mem0(csb0_mem0),
        .csb0_mem1(csb0_mem1), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0_mem0(dout0_mem0), .dout0_mem1(dout0_mem1)
    );

    always #5 clk = ~clk;

    // behavioural 1rw macros: sample on rising edge, read data registered
    logic [31:0] sram0 [512];
    logic [31:0] sram1 [512];
    always @(posedge clk) begin
        if (!csb0_mem0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram0[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else dout0_mem0 <= sram0[addr0];
        end
    end
    always @(posedge clk) begin
        if (!csb0_mem1) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram1[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else dout0_mem1 <= sram1[addr0];
        end
    end

    // reference: flat word window plus last value returned to the bus
    logic [31:0] ref_mem [1024];
    bit          ref_vld [1024];
    logic [31:0] last_rd;
    bit          last_known;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    task automatic ref_write(input logic [9:0] idx, input logic [3:0] s, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        if (s == 4'hF) ref_vld[idx] = 1'b1;
    endtask

    // one bus transfer starting at a negedge; returns what the port did
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic [1:0] csb,
                        output logic wb, output logic [8:0] a0, output logic [3:0] wm,
                        output logic [31:0] di);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; datwr = d;
        lat = 99; rd = '0; csb = 2'b11; wb = 1'b1; a0 = '0; wm = '0; di = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) begin
                csb = {csb0_mem1, csb0_mem0}; wb = web0; a0 = addr0; wm = wmask0; di = din0;
            end
            if (ack) begin lat = n; rd = datrd; break; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("xfer", "ack_one_cycle", {31'b0, ack}, 32'h0);
    endtask

    task automatic run_op(input string tag, input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int e_lat, input logic [1:0] e_csb,
                          input logic [8:0] e_a0, input logic [3:0] e_wm, input logic [31:0] e_rd);
        int lat; logic [31:0] rd, di; logic [1:0] csb; logic wb; logic [8:0] a0; logic [3:0] wm;
        xfer(w, a, s, d, lat, rd, csb, wb, a0, wm, di);
        chk(tag, "latency", lat, e_lat);
        chk(tag, "csb{1,0}", {30'b0, csb}, {30'b0, e_csb});
        chk(tag, "web0", {31'b0, wb}, {31'b0, ~w});
        chk(tag, "addr0", {23'b0, a0}, {23'b0, e_a0});
        chk(tag, "wmask0", {28'b0, wm}, {28'b0, e_wm});
        if (w) begin
            chk(tag, "din0", di, d);
            if (last_known) chk(tag, "datrd_hold", datrd, last_rd);
            ref_write(a[11:2], s, d);
        end else begin
            chk(tag, "datrd", rd, e_rd);
            last_rd = e_rd; last_known = 1'b1;
        end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        int          lat;
        logic [1:0]  csb;
        logic [8:0]  a0;
        logic [3:0]  wm;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; datwr = 0;
        last_rd = 0; last_known = 1'b1;
        for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; ref_vld[i] = 1'b0; end

        //             we  adr            sel   wdata          lat csb    a0      wm    rdata
        tbl[0] = '{1'b1, 32'h3010_0004, 4'hF, 32'hDEADBEEF, 2, 2'b10, 9'h001, 4'hF, 32'h0};
        tbl[1] = '{1'b0, 32'h3010_0004, 4'hF, 32'h0,        3, 2'b10, 9'h001, 4'h0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h3010_0804, 4'hF, 32'h12345678, 2, 2'b01, 9'h001, 4'hF, 32'h0};
        tbl[3] = '{1'b0, 32'h3010_0804, 4'h0, 32'h0,        3, 2'b01, 9'h001, 4'h0, 32'h12345678};
        tbl[4] = '{1'b1, 32'h3010_0FFC, 4'hF, 32'hAABBCCDD, 2, 2'b01, 9'h1FF, 4'hF, 32'h0};
        tbl[5] = '{1'b1, 32'h3010_0FFC, 4'h4, 32'h11223344, 2, 2'b01, 9'h1FF, 4'h4, 32'h0};
        tbl[6] = '{1'b0, 32'h3010_0FFE, 4'hF, 32'h0,        3, 2'b01, 9'h1FF, 4'h0, 32'hAA22CCDD};
        tbl[7] = '{1'b1, 32'h3010_0004, 4'h0, 32'h0,        2, 2'b10, 9'h001, 4'h0, 32'h0};
        tbl[8] = '{1'b0, 32'h3010_0005, 4'hF, 32'h0,        3, 2'b10, 9'h001, 4'h0, 32'hDEADBEEF};

        repeat (2) @(negedge clk);
        chk("reset", "csb0,csb1,web,ack", {28'b0, csb0_mem0, csb0_mem1, web0, ack}, 32'hE);
        chk("reset", "datrd", datrd, 32'h0);
        chk("reset", "wmask,addr0", {19'b0, wmask0, addr0}, 32'h0);
        chk("reset", "din0", din0, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd,
                   tbl[i].lat, tbl[i].csb, tbl[i].a0, tbl[i].wm, tbl[i].rd);

        // misses: below the window and just above it
        cyc = 1; stb = 1; we = 1; sel = 4'hF; datwr = 32'hFFFF_FFFF; adr = 32'h3000_0000;
        for (int n = 0; n < 15; n++) begin
            if (n == 10) adr = 32'h3010_1000;
            @(posedge clk); @(negedge clk);
            chk("miss", "csb0,csb1,web,ack", {28'b0, csb0_mem0, csb0_mem1, web0, ack}, 32'hE);
        end
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);

        // read aborted while the SRAM is being accessed
        cyc = 1; stb = 1; we = 0; adr = 32'h3010_0004;
        @(posedge clk); @(negedge clk);
        chk("abort", "csb0_mem0", {31'b0, csb0_mem0}, 32'h0);
        stb = 0; cyc = 0;
        for (int n = 2; n <= 3; n++) begin
            @(posedge clk); @(negedge clk);
            chk("abort", "no_ack", {31'b0, ack}, 32'h0);
        end
        last_known = 1'b0;
        run_op("after_abort", 1'b1, 32'h3010_0010, 4'hF, 32'hCAFEF00D, 2, 2'b10, 9'h004, 4'hF, 32'h0);
        run_op("after_abort_rd", 1'b0, 32'h3010_0010, 4'hF, 32'h0, 3, 2'b10, 9'h004, 4'h0, 32'hCAFEF00D);

        // random traffic against the window model
        for (int i = 0; i < 40; i++) begin
            logic [9:0] idx; bit w; logic [3:0] s; logic [31:0] d, a;
            idx = 10'($urandom_range(0, 1023));
            w   = 1'($urandom_range(0, 1));
            if (!w && !ref_vld[idx]) w = 1'b1;
            s   = 4'($urandom_range(0, 15));
            if (i < 8) s = 4'hF;
            d   = $urandom;
            a   = {20'h30100, idx, 2'($urandom_range(0, 3))};
            run_op($sformatf("rnd%0d", i), w, a, s, d, w ? 2 : 3,
                   idx[9] ? 2'b01 : 2'b10, idx[8:0], w ? s : 4'h0, ref_mem[idx]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // asynchronous reset in the middle of a read
        cyc = 1; stb = 1; we = 0; adr = 32'h3010_0804;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst", "csb0,csb1,web,ack", {28'b0, csb0_mem0, csb0_mem1, web0, ack}, 32'hE);
        chk("midrst", "datrd", datrd, 32'h0);
        chk("midrst", "wmask,addr0", {19'b0, wmask0, addr0}, 32'h0);
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0; last_known = 1'b1;
        @(negedge clk);
        chk("midrst", "no_ack", {31'b0, ack}, 32'h0);
        run_op("post_rst_wr", 1'b1, 32'h3010_0808, 4'h3, 32'h0000_BEEF, 2, 2'b01, 9'h002, 4'h3, 32'h0);
        run_op("post_rst_rd", 1'b0, 32'h3010_0804, 4'hF, 32'h0, 3, 2'b01, 9'h001, 4'h0, ref_mem[10'h201]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
